// File: rtl/counter_driver.sv
// rtl/counter_driver.sv - steers a +3/-5 step counter to a requested value
// Optional feedback check: define COUNTER_DRIVER_CHECK_EN.
module counter_driver (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] target,
  input  logic [3:0] q_in,
  output logic       s,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic [3:0] steps,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    STEP,
    CHECK,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] tgt_q;
  logic [3:0] n_q;

  logic [3:0] diff_up;
  logic [3:0] diff_dn;
  logic [3:0] du;
  logic [3:0] dd;
  logic       up_sel;
  logic [3:0] n_plan;

  // 11 and 13 are the inverses of 3 and 5 mod 16, so these give step counts directly
  always_comb begin
    diff_up = tgt_q - q_in;
    diff_dn = q_in - tgt_q;
    du      = diff_up * 4'd11;
    dd      = diff_dn * 4'd13;
    up_sel  = (du <= dd);
    n_plan  = up_sel ? du : dd;
  end

`ifdef COUNTER_DRIVER_CHECK_EN
  logic [3:0] expected;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      en    <= 1'b1;
      s     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      steps <= 4'd0;
      tgt_q <= 4'd0;
      n_q   <= 4'd0;
`ifdef COUNTER_DRIVER_CHECK_EN
      expected <= 4'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          en <= 1'b1;
          if (start) begin
            tgt_q <= target;
            steps <= 4'd0;
            busy  <= 1'b1;
            state <= PLAN;
`ifdef COUNTER_DRIVER_CHECK_EN
            err_q <= 1'b0;
`endif
          end
        end
        PLAN: begin
          s   <= up_sel;
          n_q <= n_plan;
`ifdef COUNTER_DRIVER_CHECK_EN
          expected <= q_in;
`endif
          if (n_plan == 4'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            en    <= 1'b0;
            state <= STEP;
          end
        end
        STEP: begin
          en    <= 1'b1;
          steps <= steps + 4'd1;
`ifdef COUNTER_DRIVER_CHECK_EN
          expected <= s ? (expected + 4'd3) : (expected - 4'd5);
`endif
          state <= CHECK;
        end
        CHECK: begin
`ifdef COUNTER_DRIVER_CHECK_EN
          if (q_in != expected) begin
            err_q <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else
`endif
          if (steps == n_q) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            en    <= 1'b0;
            state <= STEP;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// tb/tb_counter_driver.sv - randomized bench for counter_driver with a step-counter model
module tb_counter_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] target = 4'd0;
  logic [3:0] q_in;
  logic       s;
  logic       en;
  logic       busy;
  logic       done;
  logic [3:0] steps;
  logic       err;

  logic [3:0] q = 4'd0;
  logic       ld = 1'b0;
  logic [3:0] ld_val = 4'd0;
  logic       force0 = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  counter_driver dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .target (target),
    .q_in   (q_in),
    .s      (s),
    .en     (en),
    .busy   (busy),
    .done   (done),
    .steps  (steps),
    .err    (err)
  );

  always #5 clk = ~clk;

  // external step counter: +3 when s=1, -5 when s=0, moves only while en=0
  always @(posedge clk) begin
    if (ld) q <= ld_val;
    else if (!en) q <= s ? q + 4'd3 : q - 4'd5;
  end

  assign q_in = force0 ? 4'd0 : q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // shortest path by brute search over step counts
  task automatic plan_ref(input logic [3:0] cur, input logic [3:0] tgt,
                          output logic exp_s, output int exp_n);
    int k, m;
    k = -1;
    m = -1;
    for (int i = 0; i < 16; i++) begin
      if (k < 0 && ((cur + 3 * i) % 16) == tgt) k = i;
      if (m < 0 && ((cur + 16 * 5 - 5 * i) % 16) == tgt) m = i;
    end
    exp_s = (k <= m);
    exp_n = exp_s ? k : m;
  endtask

  // mode 0: plain, 1: extra start while busy, 2: q_in forced to 0 in first CHECK
  task automatic run_req(input logic [3:0] cur, input logic [3:0] tgt, input int mode);
    logic       exp_s;
    int         exp_n;
    int         exp_steps, exp_done, exp_err, exp_lows;
    logic [3:0] exp_q;
    int         done_cyc;
    int         lows;

    plan_ref(cur, tgt, exp_s, exp_n);
    exp_steps = exp_n;
    exp_done  = 2 * exp_n + 1;
    exp_err   = 0;
    exp_lows  = exp_n;
    exp_q     = tgt;
`ifdef COUNTER_DRIVER_CHECK_EN
    if (mode == 2) begin
      exp_steps = 1;
      exp_done  = 3;
      exp_err   = 1;
      exp_lows  = 1;
      exp_q     = cur + 4'd3;
    end
`endif

    ld_val = cur;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    target = tgt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    target = 4'($urandom_range(15, 0));
    check("plan_busy", busy, 1);

    done_cyc = -1;
    lows = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      check("busy", busy, 1);
      if (!en) begin
        lows++;
        check("step_s", s, exp_s);
      end
      if (mode == 1) begin
        start  = (c == 1);
        target = tgt ^ 4'd5;
      end
      if (mode == 2) force0 = (c == 2);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    force0 = 1'b0;
    if (done_cyc < 0) check("timeout", 0, 1);
    check("done_cycle", done_cyc, exp_done);
    check("en_low_cycles", lows, exp_lows);
    check("steps", steps, exp_steps);
    check("s_final", s, exp_s);
    check("err", err, exp_err);
    check("q_final", q, exp_q);

    @(posedge clk); #1;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_en", en, 1);
    check("steps_hold", steps, exp_steps);
    check("err_hold", err, exp_err);
  endtask

  initial begin
    int dones;
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", en, 1);
    check("rst_s", s, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_steps", steps, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_req(4'd0, 4'd3, 0);
    run_req(4'd0, 4'd11, 0);
    run_req(4'd7, 4'd7, 0);
    run_req(4'd0, 4'd8, 0);
    run_req(4'd0, 4'd6, 2);
    run_req(4'd0, 4'd3, 1);

    // reset while the second STEP is active
    ld_val = 4'd0;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    target = 4'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("second_step_en", en, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_en", en, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_steps", steps, 0);
    check("abort_s", s, 0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);

    for (int i = 0; i < 25; i++)
      run_req(4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
